// File: rtl/lvds_link_pkg.sv
// Shared definitions for both ends of the 12-bit LVDS link:
// word-type encoding, default training/idle words and sequencer states.
package lvds_link_pkg;

  localparam int LINK_DATA_WIDTH = 12;

  localparam logic [LINK_DATA_WIDTH-1:0] DEF_TRAIN_PATTERN = 12'hF00;
  localparam logic [LINK_DATA_WIDTH-1:0] DEF_IDLE_PATTERN  = 12'hA5A;

  localparam logic [1:0] WT_TRAIN = 2'd0;
  localparam logic [1:0] WT_IDLE  = 2'd1;
  localparam logic [1:0] WT_DATA  = 2'd2;

  typedef enum logic {
    ST_TRAIN = 1'b0,
    ST_RUN   = 1'b1
  } tx_state_e;

endpackage

// File: rtl/tx_word_sequencer.sv
// Word sequencer for the LVDS transmitter: slot counter, training count and
// choice of the next word (training, idle or user data) at each boundary.
//
// state    | meaning
// ST_TRAIN | sending TRAIN_WORDS training words after reset, data_ready held low
// ST_RUN   | sending user data when offered at a boundary, idle word otherwise
module tx_word_sequencer
  import lvds_link_pkg::*;
#(
  parameter int                    DATA_WIDTH    = LINK_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int                    TRAIN_WORDS   = 16,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN  = DEF_IDLE_PATTERN,
  parameter int                    WORD_LEN      = DATA_WIDTH,
  localparam int                   BW            = $clog2(WORD_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  train_done,
  output logic                  boundary,
  output logic [BW-1:0]         bit_cnt,
  output logic [DATA_WIDTH-1:0] load_word,
  output logic [1:0]            load_type
);

  localparam int            CW       = $clog2(TRAIN_WORDS + 1);
  localparam logic [CW-1:0] TW_LAST  = CW'(TRAIN_WORDS);
  localparam logic [BW-1:0] SLOT_END = BW'(WORD_LEN - 1);

  tx_state_e     state, state_nxt;
  logic [CW-1:0] train_cnt, train_cnt_nxt;

  assign boundary = (bit_cnt == SLOT_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_TRAIN;
      train_cnt  <= '0;
      bit_cnt    <= SLOT_END;
      train_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      train_cnt  <= train_cnt_nxt;
      bit_cnt    <= boundary ? '0 : bit_cnt + 1'b1;
      train_done <= (state_nxt == ST_RUN);
    end
  end

  always_comb begin
    state_nxt     = state;
    train_cnt_nxt = train_cnt;
    load_word     = TRAIN_PATTERN;
    load_type     = WT_TRAIN;
    data_ready    = 1'b0;
    case (state)
      ST_TRAIN: begin
        // The boundary that closes the last training word already loads idle.
        if (boundary) begin
          if (train_cnt == TW_LAST) begin
            state_nxt = ST_RUN;
            load_word = IDLE_PATTERN;
            load_type = WT_IDLE;
          end else begin
            train_cnt_nxt = train_cnt + 1'b1;
          end
        end
      end
      ST_RUN: begin
        data_ready = boundary;
        if (boundary && data_valid) begin
          load_word = data_in;
          load_type = WT_DATA;
        end else begin
          load_word = IDLE_PATTERN;
          load_type = WT_IDLE;
        end
      end
      default: state_nxt = ST_TRAIN;
    endcase
  end

endmodule

// File: rtl/serializer_12bit_tx.sv
// 12-bit LVDS link transmitter: parallel words to MSB-first serial bits plus frame marker.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word's LSB.
module serializer_12bit_tx
  import lvds_link_pkg::*;
#(
  parameter int                    DATA_WIDTH    = LINK_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int                    TRAIN_WORDS   = 16,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN  = DEF_IDLE_PATTERN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  serial_out,
  output logic                  frame_out,
  output logic                  train_done,
  output logic [1:0]            word_type
);

`ifdef SERIALIZER_PARITY_EN
  localparam int WORD_LEN = DATA_WIDTH + 1;
`else
  localparam int WORD_LEN = DATA_WIDTH;
`endif
  localparam int            BW   = $clog2(WORD_LEN);
  localparam logic [BW-1:0] HALF = BW'(DATA_WIDTH / 2);

  logic                  boundary;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         next_slot;
  logic [DATA_WIDTH-1:0] load_word;
  logic [1:0]            load_type;
  logic [WORD_LEN-1:0]   load_vec;
  logic [WORD_LEN-2:0]   shift_reg;

  tx_word_sequencer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .TRAIN_PATTERN(TRAIN_PATTERN),
    .TRAIN_WORDS  (TRAIN_WORDS),
    .IDLE_PATTERN (IDLE_PATTERN),
    .WORD_LEN     (WORD_LEN)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .train_done(train_done),
    .boundary  (boundary),
    .bit_cnt   (bit_cnt),
    .load_word (load_word),
    .load_type (load_type)
  );

`ifdef SERIALIZER_PARITY_EN
  assign load_vec = {load_word, ^load_word};
`else
  assign load_vec = load_word;
`endif

  assign next_slot = bit_cnt + 1'b1;

  // The MSB goes straight to serial_out at load so it appears one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      serial_out <= 1'b0;
      frame_out  <= 1'b0;
      word_type  <= WT_TRAIN;
      shift_reg  <= '0;
    end else if (boundary) begin
      serial_out <= load_vec[WORD_LEN-1];
      shift_reg  <= load_vec[WORD_LEN-2:0];
      frame_out  <= 1'b1;
      word_type  <= load_type;
    end else begin
      serial_out <= shift_reg[WORD_LEN-2];
      shift_reg  <= {shift_reg[WORD_LEN-3:0], 1'b0};
      frame_out  <= (next_slot < HALF);
    end
  end

endmodule

// File: tb/tb_serializer_12bit_tx.sv
// Bench for serializer_12bit_tx: directed stimulus feeds an expected-word queue,
// a loopback deserializer model pops and compares every word seen on the link.
module tb_serializer_12bit_tx;
  import lvds_link_pkg::*;

`ifdef SERIALIZER_PARITY_EN
  localparam int WL = 13;
`else
  localparam int WL = 12;
`endif
  localparam int TW   = 16;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        serial_out;
  logic        frame_out;
  logic        train_done;
  logic [1:0]  word_type;

  typedef struct {
    logic [11:0] word;
    logic [1:0]  typ;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic s_ser, s_frame;
  logic [1:0] s_type;

  serializer_12bit_tx dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .serial_out(serial_out),
    .frame_out (frame_out),
    .train_done(train_done),
    .word_type (word_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // One bit-clock: drive inputs, check handshake/status mid-cycle, queue the word loaded at a boundary.
  task automatic step(input logic v, input logic [11:0] d);
    bit bnd;
    int w;
    exp_t e;
    data_valid = v;
    data_in    = d;
    @(negedge clk);
    bnd = (cyc % WL) == 0;
    w   = cyc / WL;
    check("data_ready", {15'd0, data_ready}, {15'd0, (bnd && w > TW)});
    check("train_done", {15'd0, train_done}, {15'd0, (cyc > TW * WL)});
    s_ser   = serial_out;
    s_frame = frame_out;
    s_type  = word_type;
    if (bnd) begin
      if (w < TW) begin
        e.word = 12'hF00; e.typ = WT_TRAIN;
      end else if (v && w > TW) begin
        e.word = d; e.typ = WT_DATA;
      end else begin
        e.word = 12'hA5A; e.typ = WT_IDLE;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_boundary();
    while ((cyc % WL) != 0) step(1'b0, 12'h000);
  endtask

  // Loopback deserializer: word starts where frame_out rises, WL bits collected MSB first.
  int          mcyc = 0;
  int          last_start = 0;
  bit          have_start = 0;
  bit          collecting = 0;
  bit          frame_err = 0;
  logic        prev_frame = 1'b0;
  int          slot = 0;
  logic [12:0] got_vec;
  logic [12:0] exp_vec;
  logic [1:0]  got_type;

  always @(negedge clk) begin
    exp_t e;
    mcyc++;
    if (rst) begin
      collecting = 0;
      have_start = 0;
    end else begin
      if (!collecting && frame_out && !prev_frame) begin
        if (have_start) check("word_spacing", 16'(mcyc - last_start), 16'(WL));
        last_start = mcyc;
        have_start = 1;
        collecting = 1;
        slot       = 0;
        got_vec    = '0;
        frame_err  = 0;
        got_type   = word_type;
      end
      if (collecting) begin
        got_vec = {got_vec[11:0], serial_out};
        if (frame_out !== (slot < HALF)) frame_err = 1;
        slot++;
        if (slot == WL) begin
          collecting = 0;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL word_queue: got word %h with nothing expected", got_vec);
          end else begin
            e = exp_q.pop_front();
            exp_vec = (WL == 13) ? {e.word, ^e.word} : {1'b0, e.word};
            if (got_vec !== exp_vec || got_type !== e.typ || frame_err) begin
              miscompares++;
              $display("FAIL word: got bits %h type %0d frame_err %0d expected bits %h type %0d",
                       got_vec, got_type, frame_err, exp_vec, e.typ);
            end
          end
        end
      end
    end
    prev_frame = frame_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] stream [3];
    stream = '{12'hFFF, 12'h000, 12'h801};
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_serial", {15'd0, serial_out}, 16'd0);
    check("rst_frame",  {15'd0, frame_out},  16'd0);
    check("rst_type",   {14'd0, word_type},  16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;

    // training then idle
    repeat (20 * WL) step(1'b0, 12'h000);

    // single word: type and frame with its MSB
    goto_boundary();
    step(1'b1, 12'h123);
    step(1'b0, 12'h000);
    check("t1_type",  {14'd0, s_type},  {14'd0, WT_DATA});
    check("t1_frame", {15'd0, s_frame}, 16'd1);
    check("t1_msb",   {15'd0, s_ser},   16'd0);
    repeat (3 * WL) step(1'b0, 12'h000);

    // back-to-back stream with data_valid held high
    goto_boundary();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < WL; j++) begin
        step(1'b1, stream[i]);
        if (i == 0 && j == 0) check("idle_lsb_before", {15'd0, s_ser}, 16'd0);
        if (i == 0 && j == 1) check("fff_msb_latency", {15'd0, s_ser}, 16'd1);
      end
    end
    repeat (2 * WL) step(1'b0, 12'h000);

    // valid only off-boundary: must not be consumed
    goto_boundary();
    repeat (4) step(1'b0, 12'h000);
    step(1'b1, 12'hBAD);
    goto_boundary();
    repeat (2 * WL) step(1'b0, 12'h000);

    // parity-sensitive words
    goto_boundary();
    repeat (WL) step(1'b1, 12'h007);
    repeat (WL) step(1'b1, 12'h003);
    repeat (2 * WL) step(1'b0, 12'h000);

    // reset while slot 5 of a data word is on the line
    goto_boundary();
    step(1'b1, 12'h3C3);
    repeat (5) step(1'b0, 12'h000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_serial", {15'd0, serial_out}, 16'd0);
    check("mid_rst_frame",  {15'd0, frame_out},  16'd0);
    check("mid_rst_done",   {15'd0, train_done}, 16'd0);
    check("mid_rst_ready",  {15'd0, data_ready}, 16'd0);
    check("mid_rst_type",   {14'd0, word_type},  16'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    repeat (18 * WL) step(1'b0, 12'h000);

    check("queue_drained", 16'(exp_q.size() <= 1), 16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serializer_12bit_tx.md
Name: serializer_12bit_tx

Overview:
- Fabric-logic serializer: converts 12-bit parallel words to a 1-bit-per-clock serial stream plus a frame marker.
- Transmit end of the 12-bit LVDS link; its output drives the serial input of the 12-bit deserializer, either on the far board or in loopback.
- After reset it emits training words so the receiver can bit-align and word-align.
- With no user data, it emits an idle word continuously, so the frame marker never stops.

Parameters:
- DATA_WIDTH, 12, payload bits per word (fixed at 12 in this link; must be even and at least 4).
- TRAIN_PATTERN, 12'hF00, word sent during post-reset training.
- TRAIN_WORDS, 16, number of training words after reset (minimum 1).
- IDLE_PATTERN, 12'hA5A, word sent when no data is offered at a word boundary.

Ports:
- clk  in  1  bit clock; one serial bit per rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  parallel word to send.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  word accepted this cycle if data_valid=1.
- serial_out  out  1  serial bit stream, MSB first, registered.
- frame_out  out  1  high during the first DATA_WIDTH/2 bit slots of every word, registered.
- train_done  out  1  high once training has completed; stays high until reset.
- word_type  out  2  type of the word currently on serial_out: 0 TRAIN, 1 IDLE, 2 DATA.

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: serial_out=0, frame_out=0, data_ready=0, train_done=0, word_type=0. Internally, state=TRAIN, train_cnt=0, bit_cnt=WORD_LEN-1.
- WORD_LEN = DATA_WIDTH, or DATA_WIDTH+1 with the optional feature.
- bit_cnt counts 0..WORD_LEN-1. A "boundary" is the cycle in which bit_cnt == WORD_LEN-1; that is when the next word is loaded.
- State TRAIN:
  - At each boundary, load TRAIN_PATTERN and increment train_cnt.
  - data_ready is held at 0.
  - When the word numbered TRAIN_WORDS finishes (boundary with train_cnt == TRAIN_WORDS), go to RUN and set train_done=1 in the same cycle.
- State RUN:
  - data_ready = 1 exactly in boundary cycles, else 0.
  - At a boundary with data_valid=1: load data_in, word_type=DATA.
  - At a boundary with data_valid=0: load IDLE_PATTERN, word_type=IDLE.
  - data_valid outside boundary cycles is ignored; the word is not consumed.
- Shift: shift register shifts left every cycle; serial_out <= shift_reg MSB.
- Latency:
  - Word accepted in cycle t: its MSB appears on serial_out at t+1 and its LSB at t+DATA_WIDTH.
  - Back-to-back words have zero gap.
- frame_out = 1 when the bit on serial_out is in slot 0..DATA_WIDTH/2-1 of its word.
  - Default: 6 high, 6 low.
  - With parity, the parity slot is low.
- word_type changes in the same cycle as the new word's MSB.
- Reset mid-word:
  - The word is truncated.
  - Outputs return to reset values on the next edge.
  - Training restarts from train_cnt=0.
- rst has priority over every other event.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - A single even-parity bit over the DATA_WIDTH payload bits is appended after the LSB, giving WORD_LEN=DATA_WIDTH+1.
  - Parity is computed at load time.
  - Training and idle words also carry parity.
- Undefined: WORD_LEN=DATA_WIDTH and no parity logic is generated.

Decomposition:
- Shared package lvds_link_pkg holds:
  - word_type encoding constants: WT_TRAIN=2'd0, WT_IDLE=2'd1, WT_DATA=2'd2.
  - default TRAIN_PATTERN and IDLE_PATTERN, shared with the receiver's aligner.
  - DATA_WIDTH=12.
- One sub-module, tx_word_sequencer, is natural: TRAIN/RUN FSM, train_cnt, bit_cnt, word selection.
- The top level holds the shift register, parity and output registers.

Test Plan:
1. Reset release, data_valid=0 for 20 words -> 16 words of 12'hF00 (bits 111100000000), then 12'hA5A repeating. train_done rises at the boundary ending word 16. data_ready is never high before that.
2. After training, offer 12'h123 at a boundary -> serial_out shows 0001_0010_0011 on cycles t+1..t+12. word_type=2 in the same cycle as that MSB. frame_out high exactly on cycles t+1..t+6.
3. Continuous stream 12'hFFF, 12'h000, 12'h801 with data_valid held high -> each accepted on consecutive boundaries, 12 cycles apart, no idle bits in between. Each word decoded correctly by a DUT-to-deserializer loopback model.
4. data_valid pulsed high for one non-boundary cycle -> no acceptance. The next word is 12'hA5A.
5. rst asserted at bit 5 of a 12'h3C3 data word -> next edge: serial_out=0, frame_out=0, train_done=0, data_ready=0. Then a full 16-word training sequence restarts.
6. SERIALIZER_PARITY_EN defined, send 12'h007 -> 13-bit slot ending with parity bit 1. 12'h003 gives parity bit 0. Boundary spacing is 13 cycles.
